// File: rtl/bsg_dmc_ui_burst_adapter_if.sv
// rtl/bsg_dmc_ui_burst_adapter_if.sv - UI request/data and DMC app_* signal bundle for the burst adapter
interface bsg_dmc_ui_burst_adapter_if #(
   parameter int ui_addr_width_p = 28,
   parameter int ui_data_width_p = 32
);
   localparam int mask_width_lp = ui_data_width_p / 8;

   // request stream
   logic                       req_v_i;
   logic                       req_write_i;
   logic [ui_addr_width_p-1:0] req_addr_i;
   logic                       req_ready_o;

   // write data stream
   logic                       wdata_v_i;
   logic [ui_data_width_p-1:0] wdata_i;
   logic [mask_width_lp-1:0]   wmask_i;
   logic                       wdata_ready_o;

   // read return stream
   logic                       rdata_v_o;
   logic [ui_data_width_p-1:0] rdata_o;
   logic                       rdata_last_o;
   logic                       rdata_yumi_i;

   // DMC app_* side
   logic [ui_addr_width_p-1:0] app_addr_o;
   logic [2:0]                 app_cmd_o;
   logic                       app_en_o;
   logic                       app_rdy_i;
   logic                       app_wdf_wren_o;
   logic [ui_data_width_p-1:0] app_wdf_data_o;
   logic [mask_width_lp-1:0]   app_wdf_mask_o;
   logic                       app_wdf_end_o;
   logic                       app_wdf_rdy_i;
   logic                       app_rd_data_valid_i;
   logic [ui_data_width_p-1:0] app_rd_data_i;
   logic                       app_rd_data_end_i;

   logic                       err_o;

   // adapter side
   modport slave (
      input  req_v_i, req_write_i, req_addr_i,
      output req_ready_o,
      input  wdata_v_i, wdata_i, wmask_i,
      output wdata_ready_o,
      output rdata_v_o, rdata_o, rdata_last_o,
      input  rdata_yumi_i,
      output app_addr_o, app_cmd_o, app_en_o,
      input  app_rdy_i,
      output app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
      input  app_wdf_rdy_i,
      input  app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i,
      output err_o
   );

   // requester / DMC model side
   modport master (
      output req_v_i, req_write_i, req_addr_i,
      input  req_ready_o,
      output wdata_v_i, wdata_i, wmask_i,
      input  wdata_ready_o,
      input  rdata_v_o, rdata_o, rdata_last_o,
      output rdata_yumi_i,
      input  app_addr_o, app_cmd_o, app_en_o,
      output app_rdy_i,
      input  app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o,
      output app_wdf_rdy_i,
      output app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i,
      input  err_o
   );
endinterface

// File: rtl/bsg_dmc_ui_burst_adapter.sv
// rtl/bsg_dmc_ui_burst_adapter.sv - UI request/wdata to DMC app_* bursts with credit-protected read FIFO; optional checks via BSG_DMC_UI_BURST_ADAPTER_CHECK_EN
module bsg_dmc_ui_burst_adapter #(
   parameter int ui_addr_width_p = 28,
   parameter int ui_data_width_p = 32,
   parameter int ui_burst_len_p  = 4,
   parameter int rd_fifo_els_p   = 8
) (
   input  logic clk_i,
   input  logic reset_n_i,
   bsg_dmc_ui_burst_adapter_if.slave bus
);
   localparam int lg_burst_lp     = $clog2(ui_burst_len_p);
   localparam int credit_width_lp = $clog2(rd_fifo_els_p + 1);
   localparam int ptr_width_lp    = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;

   localparam logic [2:0] cmd_wr_lp = 3'b000;
   localparam logic [2:0] cmd_rd_lp = 3'b001;

   localparam logic [credit_width_lp-1:0] burst_credits_lp = credit_width_lp'(ui_burst_len_p);
   localparam logic [credit_width_lp-1:0] fifo_els_lp      = credit_width_lp'(rd_fifo_els_p);
   localparam logic [lg_burst_lp-1:0]     last_beat_lp     = lg_burst_lp'(ui_burst_len_p - 1);
   localparam logic [ptr_width_lp-1:0]    last_ptr_lp      = ptr_width_lp'(rd_fifo_els_p - 1);

   typedef enum logic [1:0] {IDLE, CMD, WDATA} state_e;

   state_e                     state_r;
   logic                       write_r;
   logic [lg_burst_lp-1:0]     wbeat_r;
   logic [lg_burst_lp-1:0]     rbeat_r;
   logic [credit_width_lp-1:0] credits_r;
   logic [credit_width_lp-1:0] count_r;
   logic [ptr_width_lp-1:0]    wptr_r;
   logic [ptr_width_lp-1:0]    rptr_r;
   logic [ui_data_width_p-1:0] data_mem_r [rd_fifo_els_p];
   logic [rd_fifo_els_p-1:0]   last_mem_r;

   logic in_wdata;
   logic req_fire;
   logic cmd_fire;
   logic rd_cmd_fire;
   logic wbeat_fire;
   logic wlast;
   logic rlast;
   logic enq;
   logic deq;

   assign in_wdata    = (state_r == WDATA);
   assign req_fire    = bus.req_v_i & bus.req_ready_o;
   assign cmd_fire    = bus.app_en_o & bus.app_rdy_i;
   assign rd_cmd_fire = cmd_fire & ~write_r;
   assign wlast       = (wbeat_r == last_beat_lp);
   assign wbeat_fire  = bus.app_wdf_wren_o & bus.app_wdf_rdy_i;
   assign rlast       = (rbeat_r == last_beat_lp);
   assign enq         = bus.app_rd_data_valid_i;
   assign deq         = bus.rdata_v_o & bus.rdata_yumi_i;

   // Reads are only taken when a whole burst of FIFO space is reserved, since
   // the DMC cannot be stalled once it starts returning data. Gated by reset
   // so the output drops immediately when reset is asserted.
   assign bus.req_ready_o = reset_n_i & (state_r == IDLE)
                          & (bus.req_write_i | (credits_r >= burst_credits_lp));

   // Write beats flow straight through while a write burst is in progress.
   assign bus.wdata_ready_o  = in_wdata & bus.app_wdf_rdy_i;
   assign bus.app_wdf_wren_o = in_wdata & bus.wdata_v_i;
   assign bus.app_wdf_data_o = in_wdata ? bus.wdata_i : '0;
   assign bus.app_wdf_mask_o = in_wdata ? bus.wmask_i : '0;
   assign bus.app_wdf_end_o  = bus.app_wdf_wren_o & wlast;

   // Read return: outputs masked when empty so stale entries never show.
   assign bus.rdata_v_o    = (count_r != '0);
   assign bus.rdata_o      = bus.rdata_v_o ? data_mem_r[rptr_r] : '0;
   assign bus.rdata_last_o = bus.rdata_v_o & last_mem_r[rptr_r];

   // Command FSM: latch request, hold command until accepted, then count write beats.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r        <= IDLE;
         write_r        <= 1'b0;
         wbeat_r        <= '0;
         bus.app_en_o   <= 1'b0;
         bus.app_cmd_o  <= '0;
         bus.app_addr_o <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_fire) begin
                  write_r        <= bus.req_write_i;
                  bus.app_addr_o <= bus.req_addr_i;
                  bus.app_cmd_o  <= bus.req_write_i ? cmd_wr_lp : cmd_rd_lp;
                  bus.app_en_o   <= 1'b1;
                  state_r        <= CMD;
               end
            end
            CMD: begin
               if (bus.app_rdy_i) begin
                  bus.app_en_o <= 1'b0;
                  wbeat_r      <= '0;
                  state_r      <= write_r ? WDATA : IDLE;
               end
            end
            WDATA: begin
               if (wbeat_fire) begin
                  wbeat_r <= wbeat_r + 1'b1;
                  if (wlast) begin
                     state_r <= IDLE;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Credits track free FIFO space not yet promised to an issued read.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         credits_r <= fifo_els_lp;
      end else begin
         credits_r <= credits_r
                    - (rd_cmd_fire ? burst_credits_lp : '0)
                    + credit_width_lp'(deq);
      end
   end

   // FIFO pointers, occupancy and the read-beat counter that generates last.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         rbeat_r <= '0;
      end else begin
         if (enq) begin
            wptr_r  <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + 1'b1;
            rbeat_r <= rbeat_r + 1'b1;
         end
         if (deq) begin
            rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + 1'b1;
         end
         count_r <= count_r + credit_width_lp'(enq) - credit_width_lp'(deq);
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         data_mem_r[wptr_r] <= bus.app_rd_data_i;
         last_mem_r[wptr_r] <= rlast;
      end
   end

`ifdef BSG_DMC_UI_BURST_ADAPTER_CHECK_EN
   logic [credit_width_lp-1:0] outstanding;
   logic                       err_set;

   // Beats owed by the DMC: reserved space that is not yet filled.
   assign outstanding = fifo_els_lp - credits_r - count_r;
   assign err_set     = (enq & (bus.app_rd_data_end_i != rlast))
                      | (enq & (outstanding == '0))
                      | (cmd_fire & (|bus.app_addr_o[lg_burst_lp-1:0]));

   // Sticky protocol error flag.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         bus.err_o <= 1'b0;
      end else if (err_set) begin
         bus.err_o <= 1'b1;
      end
   end
`else
   logic unused_end;
   assign unused_end = bus.app_rd_data_end_i;
   assign bus.err_o  = 1'b0;
`endif

endmodule
